// File: rtl/seeed_tft_pkg.sv
// Shared constants and helpers for the 8080-bus TFT panel responder.
// Holds command constants, register-file geometry and the bus timing minimum.
package seeed_tft_pkg;

    localparam logic [7:0] MEM_WRITE_CMD_DEFAULT = 8'h2C;
    localparam int         REG_IDX_W             = 4;
    localparam int         REG_COUNT             = 1 << REG_IDX_W;

    // Host must hold each strobe level at least this many clk cycles.
    localparam int         BUS_MIN_PULSE_CLK     = 3;

    typedef enum logic [1:0] {
        WR_NONE,
        WR_CMD,
        WR_REG,
        WR_GRAM
    } wr_kind_t;

    // A frame of 0 pixels behaves as a frame of 1 pixel.
    function automatic logic [31:0] last_pixel_index(input logic [31:0] num_pixels);
        return (num_pixels == 32'd0) ? 32'd0 : num_pixels - 32'd1;
    endfunction

endpackage

// File: rtl/seeed_tft_bus_sync.sv
// Synchronizer bank for the asynchronous 8080 bus pins plus strobe edge detectors.
// rs/data get one extra stage so they line up with the bus state from before wr_n rose.
module seeed_tft_bus_sync
    import seeed_tft_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n_pin,
    input  logic       rs_pin,
    input  logic       wr_n_pin,
    input  logic       rd_n_pin,
    input  logic [7:0] data_pin,
    input  logic       panel_reset_n_pin,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rs,
    output logic [7:0] data,
    output logic       panel_reset_n,
    output logic       wr_rise,
    output logic       rd_fall,
    output logic       rd_rise
);

    logic [3:0] ctl_s1;
    logic [3:0] ctl_s2;
    logic [8:0] rsd_s1;
    logic [8:0] rsd_s2;
    logic [8:0] rsd_s3;
    logic       wr_d;
    logic       rd_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctl_s1 <= 4'b1111;
            ctl_s2 <= 4'b1111;
            rsd_s1 <= '0;
            rsd_s2 <= '0;
            rsd_s3 <= '0;
            wr_d   <= 1'b1;
            rd_d   <= 1'b1;
        end else begin
            ctl_s1 <= {panel_reset_n_pin, cs_n_pin, wr_n_pin, rd_n_pin};
            ctl_s2 <= ctl_s1;
            rsd_s1 <= {rs_pin, data_pin};
            rsd_s2 <= rsd_s1;
            rsd_s3 <= rsd_s2;
            wr_d   <= ctl_s2[1];
            rd_d   <= ctl_s2[0];
        end
    end

    assign panel_reset_n = ctl_s2[3];
    assign cs_n          = ctl_s2[2];
    assign wr_n          = ctl_s2[1];
    assign rs            = rsd_s3[8];
    assign data          = rsd_s3[7:0];

    assign wr_rise = ctl_s2[1] & ~wr_d;
    assign rd_fall = ~ctl_s2[0] & rd_d;
    assign rd_rise = ctl_s2[0] & ~rd_d;

endmodule

// File: rtl/seeed_tft_panel_responder.sv
// Display-side emulator of an 8080 8-bit TFT panel: command/register decode,
// RGB565 pixel assembly, register readback and a free-running tearing-effect output.
//
// Byte-phase FSM
//   state   | meaning
//   PH_HIGH | next GRAM data byte is the pixel high byte
//   PH_LOW  | high byte held, next GRAM data byte completes the pixel
module seeed_tft_panel_responder
    import seeed_tft_pkg::*;
#(
    parameter logic [7:0]  MEM_WRITE_CMD = MEM_WRITE_CMD_DEFAULT,
    parameter logic [15:0] TE_PERIOD     = 16'd50000,
    parameter logic [15:0] TE_WIDTH      = 16'd100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_cs_n,
    input  logic        i_rs,
    input  logic        i_wr_n,
    input  logic        i_rd_n,
    input  logic [7:0]  i_data,
    output logic [7:0]  o_data,
    output logic        o_data_oe,
    input  logic        i_panel_reset_n,
    input  logic        i_te_enable,
    input  logic        i_te_polarity,
    input  logic [31:0] i_num_pixels,
    output logic        o_tearing_effect,
    output logic        o_cmd_stb,
    output logic [7:0]  o_cmd,
    output logic        o_pixel_stb,
    output logic [15:0] o_pixel_data,
    output logic [31:0] o_pixel_count,
    output logic        o_frame_done
);

    localparam logic [0:0] PH_HIGH = 1'b0;
    localparam logic [0:0] PH_LOW  = 1'b1;

    logic       cs_n_s;
    logic       wr_n_s;
    logic       rs_s;
    logic [7:0] data_s;
    logic       panel_reset_n_s;
    logic       wr_rise;
    logic       rd_fall;
    logic       rd_rise;

    seeed_tft_bus_sync u_bus_sync (
        .clk               (clk),
        .rst_n             (rst_n),
        .cs_n_pin          (i_cs_n),
        .rs_pin            (i_rs),
        .wr_n_pin          (i_wr_n),
        .rd_n_pin          (i_rd_n),
        .data_pin          (i_data),
        .panel_reset_n_pin (i_panel_reset_n),
        .cs_n              (cs_n_s),
        .wr_n              (wr_n_s),
        .rs                (rs_s),
        .data              (data_s),
        .panel_reset_n     (panel_reset_n_s),
        .wr_rise           (wr_rise),
        .rd_fall           (rd_fall),
        .rd_rise           (rd_rise)
    );

    logic [7:0]  regs [REG_COUNT];
    logic [0:0]  phase;
    logic [7:0]  pix_hi;
    wr_kind_t    wr_kind;
    logic        rd_start;
    logic [7:0]  rd_value;
    logic [31:0] last_idx;
    logic        gram_mode;

    assign gram_mode = (o_cmd == MEM_WRITE_CMD);
    assign last_idx  = last_pixel_index(i_num_pixels);
    assign rd_value  = gram_mode ? 8'h00 : regs[o_cmd[REG_IDX_W-1:0]];

    // A read that starts while wr_n is low loses to the write.
    assign rd_start  = rd_fall & ~cs_n_s & wr_n_s;

    always_comb begin
        wr_kind = WR_NONE;
        if (wr_rise && !cs_n_s) begin
            if (!rs_s)          wr_kind = WR_CMD;
            else if (gram_mode) wr_kind = WR_GRAM;
            else                wr_kind = WR_REG;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !panel_reset_n_s) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= 8'h00;
            phase         <= PH_HIGH;
            pix_hi        <= 8'h00;
            o_cmd         <= 8'h00;
            o_cmd_stb     <= 1'b0;
            o_pixel_stb   <= 1'b0;
            o_pixel_data  <= 16'h0000;
            o_pixel_count <= 32'd0;
            o_frame_done  <= 1'b0;
            o_data        <= 8'h00;
            o_data_oe     <= 1'b0;
        end else begin
            o_cmd_stb    <= 1'b0;
            o_pixel_stb  <= 1'b0;
            o_frame_done <= 1'b0;

            case (wr_kind)
                WR_CMD: begin
                    o_cmd     <= data_s;
                    o_cmd_stb <= 1'b1;
                    phase     <= PH_HIGH;
                    if (data_s == MEM_WRITE_CMD) o_pixel_count <= 32'd0;
                end
                WR_REG: begin
                    regs[o_cmd[REG_IDX_W-1:0]] <= data_s;
                end
                WR_GRAM: begin
                    if (phase == PH_HIGH) begin
                        pix_hi <= data_s;
                        phase  <= PH_LOW;
                    end else begin
                        o_pixel_data <= {pix_hi, data_s};
                        o_pixel_stb  <= 1'b1;
                        phase        <= PH_HIGH;
                        if (o_pixel_count == last_idx) begin
                            o_frame_done  <= 1'b1;
                            o_pixel_count <= 32'd0;
                        end else begin
                            o_pixel_count <= o_pixel_count + 32'd1;
                        end
                    end
                end
                default: ;
            endcase

            if (o_data_oe) begin
                if (rd_rise || cs_n_s || !wr_n_s) begin
                    o_data_oe <= 1'b0;
                    o_data    <= 8'h00;
                end
            end else if (rd_start) begin
                o_data_oe <= 1'b1;
                o_data    <= rd_value;
            end
        end
    end

    // TE keeps its phase across panel resets; only the system reset restarts it.
    logic [15:0] te_cnt;
    logic        te_active;

    assign te_active = (te_cnt < TE_WIDTH) && i_te_enable;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            te_cnt           <= 16'd0;
            o_tearing_effect <= ~i_te_polarity;
        end else begin
            te_cnt           <= (te_cnt == TE_PERIOD - 16'd1) ? 16'd0 : te_cnt + 16'd1;
            o_tearing_effect <= te_active ? i_te_polarity : ~i_te_polarity;
        end
    end

endmodule

// File: tb/tb_seeed_tft_panel_responder.sv
// Self-checking bench for seeed_tft_panel_responder: directed bus cases, TE timing
// and randomized bus traffic scored against a transaction-level panel model.
module tb_seeed_tft_panel_responder;

    localparam logic [7:0] MEM_CMD = 8'h2C;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_cs_n, i_rs, i_wr_n, i_rd_n;
    logic [7:0]  i_data;
    logic [7:0]  o_data;
    logic        o_data_oe;
    logic        i_panel_reset_n, i_te_enable, i_te_polarity;
    logic [31:0] i_num_pixels;
    logic        o_tearing_effect, o_cmd_stb, o_pixel_stb, o_frame_done;
    logic [7:0]  o_cmd;
    logic [15:0] o_pixel_data;
    logic [31:0] o_pixel_count;

    always #5 clk = ~clk;

    seeed_tft_panel_responder #(
        .MEM_WRITE_CMD (MEM_CMD),
        .TE_PERIOD     (16'd10),
        .TE_WIDTH      (16'd3)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_cs_n           (i_cs_n),
        .i_rs             (i_rs),
        .i_wr_n           (i_wr_n),
        .i_rd_n           (i_rd_n),
        .i_data           (i_data),
        .o_data           (o_data),
        .o_data_oe        (o_data_oe),
        .i_panel_reset_n  (i_panel_reset_n),
        .i_te_enable      (i_te_enable),
        .i_te_polarity    (i_te_polarity),
        .i_num_pixels     (i_num_pixels),
        .o_tearing_effect (o_tearing_effect),
        .o_cmd_stb        (o_cmd_stb),
        .o_cmd            (o_cmd),
        .o_pixel_stb      (o_pixel_stb),
        .o_pixel_data     (o_pixel_data),
        .o_pixel_count    (o_pixel_count),
        .o_frame_done     (o_frame_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed-event monitor.
    int          n_cmd_seen = 0, n_pix_seen = 0, n_fd_seen = 0;
    logic [15:0] last_pix = 16'h0;
    logic        last_fd  = 1'b0;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (o_cmd_stb) n_cmd_seen++;
            if (o_pixel_stb) begin
                n_pix_seen++;
                last_pix = o_pixel_data;
                last_fd  = o_frame_done;
            end
            if (o_frame_done) begin
                n_fd_seen++;
                check_eq("fd_with_pix", {31'd0, o_pixel_stb}, 32'd1);
            end
        end
    end

    // Transaction-level panel model.
    logic [7:0]  m_regs [16];
    logic [7:0]  m_cmd;
    logic        m_half;
    logic [7:0]  m_hi;
    int unsigned m_count;
    int          m_cmds = 0, m_pix = 0, m_frames = 0;

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_cmd   = 8'h00;
        m_half  = 1'b0;
        m_hi    = 8'h00;
        m_count = 0;
    endtask

    function automatic logic [7:0] model_read();
        return (m_cmd == MEM_CMD) ? 8'h00 : m_regs[m_cmd[3:0]];
    endfunction

    task automatic bus_write(input logic rs, input logic [7:0] d, input logic rd_too);
        int          lat;
        int          exp_lat;
        logic        is_pix;
        logic [15:0] exp_pix;
        logic        exp_fd;
        int unsigned frame_len;
        logic        any_oe;
        exp_lat = 0;
        is_pix  = 1'b0;
        exp_pix = 16'h0;
        exp_fd  = 1'b0;
        frame_len = (i_num_pixels == 0) ? 1 : i_num_pixels;
        if (!rs) begin
            m_cmd  = d;
            m_half = 1'b0;
            if (d == MEM_CMD) m_count = 0;
            exp_lat = 3;
            m_cmds++;
        end else if (m_cmd != MEM_CMD) begin
            m_regs[m_cmd[3:0]] = d;
        end else if (!m_half) begin
            m_hi   = d;
            m_half = 1'b1;
        end else begin
            exp_pix = {m_hi, d};
            m_half  = 1'b0;
            exp_fd  = (m_count + 1 == frame_len);
            m_count = exp_fd ? 0 : m_count + 1;
            m_pix++;
            if (exp_fd) m_frames++;
            is_pix  = 1'b1;
            exp_lat = 3;
        end

        any_oe = 1'b0;
        @(posedge clk); #1;
        i_cs_n = 1'b0; i_rs = rs; i_data = d; i_wr_n = 1'b0;
        if (rd_too) i_rd_n = 1'b0;
        repeat ($urandom_range(5, 3)) begin
            @(posedge clk);
            if (o_data_oe) any_oe = 1'b1;
        end
        #1 i_wr_n = 1'b1;
        i_rd_n = 1'b1;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (lat == 0 && (o_cmd_stb || o_pixel_stb)) lat = k;
            if (o_data_oe) any_oe = 1'b1;
        end
        i_cs_n = 1'b1;
        i_data = 8'($urandom);

        check_eq("evt_lat", lat, exp_lat);
        check_eq("pix_count", o_pixel_count, m_count);
        if (!rs) check_eq("cmd", {24'd0, o_cmd}, {24'd0, d});
        if (is_pix) begin
            check_eq("pix_data", {16'd0, last_pix}, {16'd0, exp_pix});
            check_eq("pix_fd", {31'd0, last_fd}, {31'd0, exp_fd});
        end
        if (rd_too) check_eq("wr_rd_oe", {31'd0, any_oe}, 32'd0);
    endtask

    task automatic bus_read();
        int         lat;
        logic [7:0] exp;
        exp = model_read();
        @(posedge clk); #1;
        i_cs_n = 1'b0; i_rs = 1'b1; i_rd_n = 1'b0;
        lat = 0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (lat == 0 && o_data_oe) lat = k;
        end
        check_eq("rd_oe_lat", lat, 3);
        check_eq("rd_data", {24'd0, o_data}, {24'd0, exp});
        i_rd_n = 1'b1;
        lat = 0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (lat == 0 && !o_data_oe) lat = k;
        end
        check_eq("rd_oe_drop", lat, 3);
        i_cs_n = 1'b1;
    endtask

    task automatic ghost_strobes();
        logic any;
        int   c0;
        any = 1'b0;
        c0  = n_cmd_seen + n_pix_seen;
        @(posedge clk); #1;
        i_cs_n = 1'b1; i_rs = 1'($urandom); i_data = 8'($urandom); i_wr_n = 1'b0;
        repeat (4) @(posedge clk);
        #1 i_wr_n = 1'b1;
        repeat (4) @(posedge clk);
        #1 i_rd_n = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (o_data_oe) any = 1'b1;
        end
        i_rd_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check_eq("ghost_evt", n_cmd_seen + n_pix_seen, c0);
        check_eq("ghost_oe", {31'd0, any}, 32'd0);
    endtask

    task automatic te_measure(output int highs, output int rise_cyc);
        logic prev;
        highs    = 0;
        rise_cyc = -1;
        @(posedge clk); #1;
        prev = o_tearing_effect;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (o_tearing_effect) highs++;
            if (rise_cyc < 0 && !prev && o_tearing_effect) rise_cyc = int'(cyc);
            prev = o_tearing_effect;
        end
    endtask

    int          n_before;
    int          hi_a, hi_b, rise_a, rise_b;
    int          r;
    logic [31:0] num_set [4];

    initial begin
        rst_n = 1'b0;
        i_cs_n = 1'b1; i_rs = 1'b0; i_wr_n = 1'b1; i_rd_n = 1'b1; i_data = 8'h00;
        i_panel_reset_n = 1'b1; i_te_enable = 1'b0; i_te_polarity = 1'b0;
        i_num_pixels = 32'd2;
        model_clear();
        repeat (4) @(posedge clk);
        #1;
        check_eq("rst_cmd_stb", {31'd0, o_cmd_stb}, 32'd0);
        check_eq("rst_cmd", {24'd0, o_cmd}, 32'd0);
        check_eq("rst_pix_stb", {31'd0, o_pixel_stb}, 32'd0);
        check_eq("rst_pix_data", {16'd0, o_pixel_data}, 32'd0);
        check_eq("rst_pix_count", o_pixel_count, 32'd0);
        check_eq("rst_fd", {31'd0, o_frame_done}, 32'd0);
        check_eq("rst_data", {24'd0, o_data}, 32'd0);
        check_eq("rst_oe", {31'd0, o_data_oe}, 32'd0);
        check_eq("rst_te", {31'd0, o_tearing_effect}, 32'd1);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Register write and readback.
        bus_write(1'b0, 8'h05, 1'b0);
        bus_write(1'b1, 8'hA5, 1'b0);
        bus_read();
        check_eq("reg05_direct", {24'd0, o_cmd}, 32'h05);

        // Two-pixel frame.
        i_num_pixels = 32'd2;
        bus_write(1'b0, MEM_CMD, 1'b0);
        bus_write(1'b1, 8'hF8, 1'b0);
        bus_write(1'b1, 8'h00, 1'b0);
        check_eq("px1_direct", {16'd0, last_pix}, 32'hF800);
        bus_write(1'b1, 8'h07, 1'b0);
        bus_write(1'b1, 8'hE0, 1'b0);
        check_eq("px2_direct", {16'd0, last_pix}, 32'h07E0);
        check_eq("px2_fd_direct", {31'd0, last_fd}, 32'd1);
        check_eq("px2_wrap_direct", o_pixel_count, 32'd0);
        bus_read();

        // Half pixel discarded by a new command.
        n_before = n_pix_seen;
        bus_write(1'b0, MEM_CMD, 1'b0);
        bus_write(1'b1, 8'h12, 1'b0);
        bus_write(1'b0, MEM_CMD, 1'b0);
        bus_write(1'b1, 8'h34, 1'b0);
        bus_write(1'b1, 8'h56, 1'b0);
        check_eq("discard_npix", n_pix_seen - n_before, 1);
        check_eq("discard_pix", {16'd0, last_pix}, 32'h3456);

        // Write and read strobes together, then strobes with cs_n high.
        bus_write(1'b0, 8'h03, 1'b1);
        bus_write(1'b1, 8'h3C, 1'b1);
        ghost_strobes();
        bus_read();

        // Tearing effect: 3 of every 10 cycles, phase kept across panel reset.
        i_te_polarity = 1'b1;
        i_te_enable   = 1'b1;
        repeat (12) @(posedge clk);
        te_measure(hi_a, rise_a);
        check_eq("te_highs", hi_a, 12);
        #1 i_panel_reset_n = 1'b0;
        repeat (5) @(posedge clk);
        #1 i_panel_reset_n = 1'b1;
        repeat (5) @(posedge clk);
        model_clear();
        check_eq("prst_cmd", {24'd0, o_cmd}, 32'd0);
        check_eq("prst_count", o_pixel_count, 32'd0);
        te_measure(hi_b, rise_b);
        check_eq("te_highs_after", hi_b, 12);
        check_eq("te_phase", (rise_b - rise_a) % 10, 0);
        bus_read();
        i_te_polarity = 1'b0;
        repeat (12) @(posedge clk);
        te_measure(hi_a, rise_a);
        check_eq("te_highs_pol0", hi_a, 28);
        i_te_enable = 1'b0;
        repeat (12) @(posedge clk);
        te_measure(hi_a, rise_a);
        check_eq("te_highs_off", hi_a, 40);

        // Randomized traffic against the model.
        num_set[0] = 32'd3;
        num_set[1] = 32'd0;
        num_set[2] = 32'd1;
        num_set[3] = 32'd4;
        for (int s = 0; s < 4; s++) begin
            bus_write(1'b0, MEM_CMD, 1'b0);
            i_num_pixels = num_set[s];
            for (int t = 0; t < 45; t++) begin
                r = $urandom_range(0, 9);
                if (r < 2) begin
                    case ($urandom_range(0, 2))
                        0:       bus_write(1'b0, MEM_CMD, 1'b0);
                        1:       bus_write(1'b0, 8'($urandom_range(0, 15)), 1'b0);
                        default: bus_write(1'b0, 8'($urandom), 1'b0);
                    endcase
                end else if (r < 8) begin
                    bus_write(1'b1, 8'($urandom), 1'b0);
                end else begin
                    bus_read();
                end
            end
        end

        repeat (4) @(posedge clk);
        #1;
        check_eq("total_cmds", n_cmd_seen, m_cmds);
        check_eq("total_pix", n_pix_seen, m_pix);
        check_eq("total_frames", n_fd_seen, m_frames);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seeed_tft_panel_responder.md
Name: seeed_tft_panel_responder

Overview:
- Display-side end of the 8080-style 8-bit parallel LCD bus (cs_n, rs, wr_n, rd_n, 8-bit data, tearing effect): a synthesizable panel emulator for loopback tests of the TFT host controller.
- Decodes command and data writes into a small register file.
- Assembles memory-write bytes into RGB565 pixels and answers register reads on the bidirectional data bus.
- Generates a periodic tearing-effect signal.

Parameters:
- MEM_WRITE_CMD, 8'h2C, command byte that opens pixel (GRAM) write mode.
- TE_PERIOD, 16'd50000, tearing-effect period in clk cycles (≥2).
- TE_WIDTH, 16'd100, tearing-effect active width in clk cycles (<TE_PERIOD).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- i_cs_n  input  1  bus chip select, active low, asynchronous.
- i_rs  input  1  register/data select (0 = command, 1 = data), asynchronous.
- i_wr_n  input  1  write strobe, active low, asynchronous; captured on rising edge.
- i_rd_n  input  1  read strobe, active low, asynchronous.
- i_data  input  8  bus data in, from the top-level io_data pad.
- o_data  output  8  bus read data.
- o_data_oe  output  1  bus drive enable; the top level tristates io_data when 0.
- i_panel_reset_n  input  1  panel reset pin, asynchronous, active low.
- i_te_enable  input  1  enables the tearing-effect generator.
- i_te_polarity  input  1  1 = TE active high, 0 = active low.
- i_num_pixels  input  32  pixels per frame (0 is treated as 1).
- o_tearing_effect  output  1  tearing-effect output.
- o_cmd_stb  output  1  one-cycle pulse per received command byte.
- o_cmd  output  8  last command byte.
- o_pixel_stb  output  1  one-cycle pulse per assembled pixel.
- o_pixel_data  output  16  assembled pixel (first byte = [15:8]).
- o_pixel_count  output  32  pixel index within the current frame.
- o_frame_done  output  1  one-cycle pulse when the last pixel of a frame is written.

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0 except o_tearing_effect = ~i_te_polarity. Register file, byte phase and TE counter cleared.
- Synchronized i_panel_reset_n low: same clearing as rst_n except the TE counter keeps running.
- Input sync: i_cs_n, i_rs, i_wr_n, i_rd_n and i_data each pass through 2 flops, plus a 3rd delay stage for rs/data.
- Bus timing requirement: strobe low ≥3 clk, high ≥3 clk. Behaviour under shorter pulses is undefined.
- Write capture: occurs on the synchronized wr_n rising edge with synchronized cs_n low. rs and data are taken from the 3rd stage, i.e. the values present while wr_n was low.
- Latency: o_cmd_stb / o_pixel_stb assert 3 clk after the wr_n rising edge at the pin.
- rs=0 (command): latch o_cmd, pulse o_cmd_stb, clear byte phase. Any pending half pixel is discarded. MEM_WRITE_CMD additionally resets o_pixel_count to 0.
- rs=1 and o_cmd≠MEM_WRITE_CMD: write the byte to reg[o_cmd[3:0]] (16 x 8 register file).
- rs=1 and o_cmd==MEM_WRITE_CMD:
  - Phase 0: store the high byte and go to phase 1.
  - Phase 1: o_pixel_data = {high, byte}, pulse o_pixel_stb, return to phase 0.
  - o_pixel_count updates after each pixel. If the count was i_num_pixels−1, pulse o_frame_done in the same cycle as o_pixel_stb and wrap to 0; otherwise increment.
- Read: on synchronized rd_n falling edge with cs_n low, o_data_oe=1 next cycle.
  - o_data = reg[o_cmd[3:0]], or 8'h00 when o_cmd==MEM_WRITE_CMD.
  - o_data is held stable until synchronized rd_n rises or cs_n rises; o_data_oe drops the cycle after either.
  - Reads never change byte phase or pixel count.
- Simultaneous wr_n and rd_n low: write wins; o_data_oe stays 0.
- Bus strobes while cs_n high: ignored entirely.
- TE counter: counts 0..TE_PERIOD−1 and wraps.
  - Active when counter < TE_WIDTH and i_te_enable=1.
  - o_tearing_effect = active ? i_te_polarity : ~i_te_polarity. Output is registered.

Decomposition:
- Package seeed_tft_pkg holds the command constants (MEM_WRITE_CMD default 8'h2C, register index width 4) and the 8080 min-pulse constant (3).
- One sub-module: seeed_tft_bus_sync. It holds the 2/3-stage synchronizer bank and edge detectors, producing wr_rise, rd_fall, rd_rise and the aligned rs/data.

Test Plan:
- Reset with bus idle (cs_n=1, wr_n=1, rd_n=1) → all outputs 0, o_data_oe=0, o_tearing_effect=~i_te_polarity.
- Command 8'h05 then data 8'hA5, then read with rs=1 → o_cmd_stb once with o_cmd=8'h05; o_data=8'hA5 while o_data_oe=1; oe drops after rd_n rises.
- i_num_pixels=2; command 8'h2C; data bytes F8,00,07,E0 → o_pixel_stb with data 16'hF800 then 16'h07E0. o_frame_done coincides with the 2nd pixel; o_pixel_count returns to 0.
- Command 8'h2C, data 8'h12, command 8'h2C, data 8'h34, 8'h56 → exactly one pixel, 16'h3456 (half pixel discarded).
- wr_n and rd_n low together, or any strobe with cs_n=1 → no o_cmd_stb, no register change, o_data_oe stays 0.
- TE_PERIOD=10, TE_WIDTH=3, i_te_polarity=1, i_te_enable=1 → o_tearing_effect high 3 of every 10 cycles. Pulsing i_panel_reset_n low does not disturb the TE phase.
